seg_byte_writer: RTL and testbench

Produces the two 12-bit seven-segment pin words (`low`, `high`) consumed by the display multiplexer. The block accepts a byte from the 6502 bus side through a valid/ready handshake and decodes one nibble per cycle through a shared hex decoder. It commits both words atomically, so the display never shows a torn value. It also supports optional leading-zero blanking and a free-running blink.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_byte_writer_if.sv | 17 +
 rtl/hex_to_seg.sv | 31 +++
 rtl/seg_byte_writer.sv | 113 +++++++++++
 tb/tb_seg_byte_writer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment byte writer: pin-word layout, blank word,
// decode state encoding and a helper that assembles a pin word.
package seg_pkg;

  localparam int SEG_LSB = 0;
  localparam int SEL_LO  = 7;
  localparam int SEL_HI  = 8;
  localparam int DP      = 9;

  // Both selects inactive (high), no segments, no decimal point.
  localparam logic [11:0] SEG_BLANK = 12'h180;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEC_LO = 2'd1,
    DEC_HI = 2'd2,
    COMMIT = 2'd3
  } state_t;

  function automatic logic [11:0] pin_word(input logic [6:0] seg, input logic dp);
    logic [11:0] w;
    w                   = SEG_BLANK;
    w[SEG_LSB +: 7]     = seg;
    w[DP]               = dp;
    return w;
  endfunction

endpackage

// File: rtl/seg_byte_writer_if.sv
// Write-side bus of the segment byte writer: valid/ready byte transfer plus busy status.
// The master holds wr_valid until it sees wr_ready; the slave accepts only when idle.
interface seg_byte_writer_if;

  logic       wr_valid;
  logic [7:0] wr_data;
  logic [1:0] wr_dp;
  logic       wr_ready;
  logic       busy;

  modport master (output wr_valid, output wr_data, output wr_dp,
                  input  wr_ready, input  busy);

  modport slave  (input  wr_valid, input  wr_data, input  wr_dp,
                  output wr_ready, output busy);

endinterface

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to gfedcba segment decode (active-high, a = bit 0).
// Zero latency, no flow control.
module hex_to_seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg_byte_writer.sv
// Byte to two seven-segment pin words; one shared decoder, atomic commit, blink and blanking.
// Accept at edge N, outputs change at N+4; wr_ready low while decoding, writes never queued.
module seg_byte_writer
  import seg_pkg::*;
#(
  parameter int LZB       = 1,
  parameter int BLINK_DIV = 22
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_byte_writer_if.slave   wr,
  input  logic               blink_en,
  output logic [11:0]        low,
  output logic [11:0]        high
);

  state_t             state_q, state_d;
  logic [7:0]         byte_q, byte_d;
  logic [1:0]         dp_q, dp_d;
  logic [11:0]        lo_s_q, lo_s_d, hi_s_q, hi_s_d;
  logic [11:0]        lo_c_q, lo_c_d, hi_c_q, hi_c_d;
  logic [11:0]        low_q, low_d, high_q, high_d;
  logic [BLINK_DIV:0] ctr_q, ctr_d;
  logic [3:0]         nibble;
  logic [6:0]         seg;

  // Single decoder time-shared between the two digits.
  assign nibble = (state_q == DEC_HI) ? byte_q[7:4] : byte_q[3:0];

  hex_to_seg u_hex (
    .nibble (nibble),
    .seg    (seg)
  );

  assign wr.wr_ready = (state_q == IDLE);
  assign wr.busy     = (state_q != IDLE);
  assign low         = low_q;
  assign high        = high_q;

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    dp_d    = dp_q;
    lo_s_d  = lo_s_q;
    hi_s_d  = hi_s_q;
    lo_c_d  = lo_c_q;
    hi_c_d  = hi_c_q;
    ctr_d   = ctr_q + {{BLINK_DIV{1'b0}}, 1'b1};

    case (state_q)
      IDLE: begin
        if (wr.wr_valid) begin
          byte_d  = wr.wr_data;
          dp_d    = wr.wr_dp;
          state_d = DEC_LO;
        end
      end
      DEC_LO: begin
        lo_s_d  = pin_word(seg, dp_q[0]);
        state_d = DEC_HI;
      end
      DEC_HI: begin
        if ((LZB != 0) && (byte_q[7:4] == 4'h0))
          hi_s_d = pin_word(7'h00, dp_q[1]);
        else
          hi_s_d = pin_word(seg, dp_q[1]);
        state_d = COMMIT;
      end
      COMMIT: begin
        // Both digits move together so the display never shows a half-updated byte.
        lo_c_d  = lo_s_q;
        hi_c_d  = hi_s_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (blink_en && ctr_q[BLINK_DIV]) begin
      low_d  = SEG_BLANK;
      high_d = SEG_BLANK;
    end else begin
      low_d  = lo_c_q;
      high_d = hi_c_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q  <= 8'h00;
      dp_q    <= 2'b00;
      lo_s_q  <= SEG_BLANK;
      hi_s_q  <= SEG_BLANK;
      lo_c_q  <= SEG_BLANK;
      hi_c_q  <= SEG_BLANK;
      low_q   <= SEG_BLANK;
      high_q  <= SEG_BLANK;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      dp_q    <= dp_d;
      lo_s_q  <= lo_s_d;
      hi_s_q  <= hi_s_d;
      lo_c_q  <= lo_c_d;
      hi_c_q  <= hi_c_d;
      low_q   <= low_d;
      high_q  <= high_d;
      ctr_q   <= ctr_d;
    end
  end

endmodule

// File: tb/tb_seg_byte_writer.sv
// Directed bench: two writers (blanking on / off) driven in lockstep with a short blink divider.
module tb_seg_byte_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        blink_en;
  logic [11:0] low_a, high_a, low_b, high_b;

  int errs   = 0;
  int checks = 0;

  seg_byte_writer_if bus_a ();
  seg_byte_writer_if bus_b ();

  assign bus_b.wr_valid = bus_a.wr_valid;
  assign bus_b.wr_data  = bus_a.wr_data;
  assign bus_b.wr_dp    = bus_a.wr_dp;

  always #5 clk = ~clk;

  seg_byte_writer #(.LZB(1), .BLINK_DIV(2)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (bus_a),
    .blink_en (blink_en),
    .low      (low_a),
    .high     (high_a)
  );

  seg_byte_writer #(.LZB(0), .BLINK_DIV(2)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (bus_b),
    .blink_en (1'b0),
    .low      (low_b),
    .high     (high_b)
  );

  // Reference blink phase: free-running 3-bit counter, output blank decided one edge later.
  logic [2:0] tb_ctr;
  logic       exp_blank;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_ctr    <= 3'd0;
      exp_blank <= 1'b0;
    end else begin
      tb_ctr    <= tb_ctr + 3'd1;
      exp_blank <= blink_en && tb_ctr[2];
    end
  end

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the byte is accepted on the following posedge, returns one negedge later.
  task automatic send(input logic [7:0] d, input logic [1:0] dp);
    bus_a.wr_valid = 1'b1;
    bus_a.wr_data  = d;
    bus_a.wr_dp    = dp;
    @(negedge clk);
    bus_a.wr_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    blink_en       = 1'b0;
    bus_a.wr_valid = 1'b0;
    bus_a.wr_data  = 8'h00;
    bus_a.wr_dp    = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    chk("rst_low",   low_a,  12'h180);
    chk("rst_high",  high_a, 12'h180);
    chk("rst_ready", 12'(bus_a.wr_ready), 12'h001);
    chk("rst_busy",  12'(bus_a.busy), 12'h000);
    repeat (10) @(negedge clk);
    chk("idle_low",  low_a,  12'h180);
    chk("idle_high", high_a, 12'h180);

    // 0x5A: ready low for three cycles, words appear four edges after acceptance.
    send(8'h5A, 2'b00);
    chk("5a_rdy1", 12'(bus_a.wr_ready), 12'h000);
    @(negedge clk);
    chk("5a_rdy2", 12'(bus_a.wr_ready), 12'h000);
    @(negedge clk);
    chk("5a_rdy3", 12'(bus_a.wr_ready), 12'h000);
    chk("5a_hold", low_a, 12'h180);
    @(negedge clk);
    chk("5a_rdy4", 12'(bus_a.wr_ready), 12'h001);
    chk("5a_pre",  low_a, 12'h180);
    @(negedge clk);
    chk("5a_low",  low_a,  12'h1F7);
    chk("5a_high", high_a, 12'h1ED);

    // 0x07 with high dp: blanked high digit keeps its dp; unblanked twin shows a zero.
    send(8'h07, 2'b10);
    repeat (4) @(negedge clk);
    chk("07_low_lzb",   low_a,  12'h187);
    chk("07_high_lzb",  high_a, 12'h380);
    chk("07_low_nolzb", low_b,  12'h187);
    chk("07_high_nolzb", high_b, 12'h3BF);

    // Back-to-back: valid held high across both bytes.
    bus_a.wr_valid = 1'b1;
    bus_a.wr_data  = 8'h11;
    bus_a.wr_dp    = 2'b00;
    @(negedge clk);
    bus_a.wr_data = 8'h22;
    chk("b2b_busy1", 12'(bus_a.busy), 12'h001);
    repeat (3) @(negedge clk);
    chk("b2b_rdy",  12'(bus_a.wr_ready), 12'h001);
    chk("b2b_old",  low_a, 12'h187);
    @(negedge clk);
    bus_a.wr_valid = 1'b0;
    chk("b2b_busy2", 12'(bus_a.busy), 12'h001);
    chk("b2b_low1",  low_a,  12'h186);
    chk("b2b_high1", high_a, 12'h186);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_hold_lo", low_a,  12'h186);
      chk("b2b_hold_hi", high_a, 12'h186);
    end
    @(negedge clk);
    chk("b2b_low2",  low_a,  12'h1DB);
    chk("b2b_high2", high_a, 12'h1DB);

    // Blink over 0x88.
    send(8'h88, 2'b00);
    repeat (4) @(negedge clk);
    chk("88_low", low_a, 12'h1FF);
    blink_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("blink_low",  low_a,  exp_blank ? 12'h180 : 12'h1FF);
      chk("blink_high", high_a, exp_blank ? 12'h180 : 12'h1FF);
    end
    blink_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("steady_low", low_a, 12'h1FF);
    end

    // Reset during DEC_HI of 0x3C.
    send(8'h3C, 2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_low",   low_a,  12'h180);
    chk("arst_high",  high_a, 12'h180);
    chk("arst_ready", 12'(bus_a.wr_ready), 12'h001);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_low",    low_a,  12'h180);
    chk("post_high",   high_a, 12'h180);
    chk("post_low_b",  low_b,  12'h180);
    chk("post_high_b", high_b, 12'h180);
    chk("post_ready",  12'(bus_a.wr_ready), 12'h001);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
